// File: rtl/ex_result_buffer_if.sv
// rtl/ex_result_buffer_if.sv - ALU-to-MEM/WB result handshake bundle.
// master drives ALU results in and takes the head entry out; slave is the buffer.
interface ex_result_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_z;
  logic        in_v;
  logic        in_n;
  logic [2:0]  in_dest;
  logic        in_wr_en;
  logic        in_flag_wr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic        out_wr_en;

  modport master (
    output in_valid, in_result, in_z, in_v, in_n, in_dest, in_wr_en, in_flag_wr,
    output out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_wr_en
  );

  modport slave (
    input  in_valid, in_result, in_z, in_v, in_n, in_dest, in_wr_en, in_flag_wr,
    input  out_ready,
    output in_ready, out_valid, out_result, out_dest, out_wr_en
  );
endinterface

// File: rtl/ex_result_buffer.sv
// rtl/ex_result_buffer.sv - 2-entry EX result FIFO with architectural flags and branch evaluation.
// Flush and reset discard all entries; flags survive flush but not reset.
module ex_result_buffer (
  input  logic                 clk,
  input  logic                 rst,
  ex_result_buffer_if.slave    bus,
  input  logic [2:0]           cond,
  input  logic                 flush,
  output logic [2:0]           flags,
  output logic                 br_taken,
  output logic [1:0]           occupancy
);

  logic [15:0] result_mem [2];
  logic [2:0]  dest_mem   [2];
  logic        wr_en_mem  [2];

  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_n;
  logic        push;
  logic        pop;
  logic        has_data;

  assign has_data     = (count != 2'd0);
  assign bus.in_ready = (count != 2'd2);
  assign bus.out_valid = has_data;
  assign occupancy    = count;

  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = has_data && bus.out_ready && !flush;

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count_n;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Payload is plain datapath storage; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr] <= bus.in_result;
      dest_mem[wr_ptr]   <= bus.in_dest;
      wr_en_mem[wr_ptr]  <= bus.in_wr_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 3'b000;
    end else if (push && bus.in_flag_wr) begin
      flags <= {bus.in_z, bus.in_v, bus.in_n};
    end
  end

  // Empty buffer reads as zero so stale payload never leaks downstream.
  always_comb begin
    bus.out_result = 16'h0000;
    bus.out_dest   = 3'd0;
    bus.out_wr_en  = 1'b0;
    if (has_data) begin
      bus.out_result = result_mem[rd_ptr];
      bus.out_dest   = dest_mem[rd_ptr];
      bus.out_wr_en  = wr_en_mem[rd_ptr];
    end
  end

  logic flag_z;
  logic flag_v;
  logic flag_n;
  logic lt;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];
  assign lt     = flag_n ^ flag_v;

  always_comb begin
    br_taken = 1'b0;
    unique case (cond)
      3'b000:  br_taken = flag_z;
      3'b001:  br_taken = !flag_z;
      3'b010:  br_taken = lt;
      3'b011:  br_taken = !lt;
      3'b100:  br_taken = !flag_z && !lt;
      3'b101:  br_taken = flag_z || lt;
      3'b110:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ex_result_buffer.sv
// tb/tb_ex_result_buffer.sv - scoreboard bench for ex_result_buffer.
// Stimulus queues expected head entries; a negedge monitor checks every pop.
module tb_ex_result_buffer;
  logic       clk;
  logic       rst;
  logic [2:0] cond;
  logic       flush;
  logic [2:0] flags;
  logic       br_taken;
  logic [1:0] occupancy;

  ex_result_buffer_if bif ();

  ex_result_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .cond      (cond),
    .flush     (flush),
    .flags     (flags),
    .br_taken  (br_taken),
    .occupancy (occupancy)
  );

  int errors = 0;
  int checks = 0;
  logic [19:0] sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && bif.out_valid && bif.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none",
                 {bif.out_result, bif.out_dest, bif.out_wr_en});
      end else begin
        check("pop_entry", {12'h0, bif.out_result, bif.out_dest, bif.out_wr_en}, {12'h0, sb_q[0]});
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic [15:0] r, input logic [2:0] d, input logic w,
                            input logic z, input logic v, input logic n, input logic fw);
    bif.in_result  = r;
    bif.in_dest    = d;
    bif.in_wr_en   = w;
    bif.in_z       = z;
    bif.in_v       = v;
    bif.in_n       = n;
    bif.in_flag_wr = fw;
    bif.in_valid   = 1'b1;
    if (!flush && sb_q.size() < 2) sb_q.push_back({r, d, w});
    step();
    bif.in_valid   = 1'b0;
    bif.in_flag_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cond = 3'b000;
    bif.in_valid = 1'b0;
    bif.in_result = 16'h0;
    bif.in_dest = 3'd0;
    bif.in_wr_en = 1'b0;
    bif.in_z = 1'b0;
    bif.in_v = 1'b0;
    bif.in_n = 1'b0;
    bif.in_flag_wr = 1'b0;
    bif.out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, bif.out_valid}, 32'd0);
    check("rst_in_ready", {31'h0, bif.in_ready}, 32'd1);
    check("rst_occupancy", {30'h0, occupancy}, 32'd0);
    check("rst_out_result", {16'h0, bif.out_result}, 32'd0);
    check("rst_flags", {29'h0, flags}, 32'd0);
    check("rst_br_eq", {31'h0, br_taken}, 32'd0);
    cond = 3'b110;
    #1;
    check("rst_br_always", {31'h0, br_taken}, 32'd1);
    repeat (2) step();
    #2 rst = 1'b0;
    step();

    // Single push, downstream stalled.
    push_cycle(16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_out_valid", {31'h0, bif.out_valid}, 32'd1);
    check("lat_out_result", {16'h0, bif.out_result}, 32'h1234);
    check("lat_occupancy", {30'h0, occupancy}, 32'd1);

    // Fill, then an ignored third push.
    push_cycle(16'habcd, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_occupancy", {30'h0, occupancy}, 32'd2);
    check("full_in_ready", {31'h0, bif.in_ready}, 32'd0);
    push_cycle(16'hffff, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_hold_occ", {30'h0, occupancy}, 32'd2);
    check("full_hold_head", {16'h0, bif.out_result}, 32'h1234);
    bif.out_ready = 1'b1;
    repeat (2) step();
    check("drain_occupancy", {30'h0, occupancy}, 32'd0);
    check("empty_out_result", {16'h0, bif.out_result}, 32'd0);
    bif.out_ready = 1'b0;

    // Simultaneous push and pop at count 1.
    push_cycle(16'h1111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.out_ready = 1'b1;
    push_cycle(16'h2222, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("simul_occupancy", {30'h0, occupancy}, 32'd1);
    check("simul_head", {16'h0, bif.out_result}, 32'h2222);
    step();

    // Flag load and branch evaluation.
    push_cycle(16'h0010, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flags_010", {29'h0, flags}, 32'b010);
    cond = 3'b010; #1 check("br_lt", {31'h0, br_taken}, 32'd1);
    cond = 3'b011; #1 check("br_ge", {31'h0, br_taken}, 32'd0);
    cond = 3'b001; #1 check("br_ne", {31'h0, br_taken}, 32'd1);
    cond = 3'b100; #1 check("br_gt", {31'h0, br_taken}, 32'd0);
    cond = 3'b101; #1 check("br_le", {31'h0, br_taken}, 32'd1);
    cond = 3'b111; #1 check("br_never", {31'h0, br_taken}, 32'd0);
    push_cycle(16'h0020, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flags_hold", {29'h0, flags}, 32'b010);
    push_cycle(16'h0030, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("flags_101", {29'h0, flags}, 32'b101);
    cond = 3'b000; #1 check("br_eq", {31'h0, br_taken}, 32'd1);
    cond = 3'b010; #1 check("br_lt2", {31'h0, br_taken}, 32'd1);
    cond = 3'b100; #1 check("br_gt2", {31'h0, br_taken}, 32'd0);
    repeat (2) step();
    bif.out_ready = 1'b0;

    // Flush with a concurrent push that would clobber flags.
    push_cycle(16'h4444, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cycle(16'h5555, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_flush_occ", {30'h0, occupancy}, 32'd2);
    flush = 1'b1;
    sb_q.delete();
    push_cycle(16'h6666, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    flush = 1'b0;
    check("flush_occupancy", {30'h0, occupancy}, 32'd0);
    check("flush_out_valid", {31'h0, bif.out_valid}, 32'd0);
    check("flush_flags", {29'h0, flags}, 32'b101);
    push_cycle(16'h5a5a, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", {16'h0, bif.out_result}, 32'h5a5a);
    check("post_flush_occ", {30'h0, occupancy}, 32'd1);
    bif.out_ready = 1'b1;
    step();
    bif.out_ready = 1'b0;

    // Asynchronous reset mid-cycle with a full buffer.
    push_cycle(16'h7777, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cycle(16'h8888, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_occ", {30'h0, occupancy}, 32'd2);
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    check("async_rst_valid", {31'h0, bif.out_valid}, 32'd0);
    check("async_rst_flags", {29'h0, flags}, 32'd0);
    check("async_rst_occ", {30'h0, occupancy}, 32'd0);
    check("async_rst_ready", {31'h0, bif.in_ready}, 32'd1);
    step();
    #2 rst = 1'b0;
    step();
    check("post_rst_occ", {30'h0, occupancy}, 32'd0);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_result_buffer.md
EX_RESULT_BUFFER -- requirements
Module: ex_result_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  ALU result presented this cycle.
REQ-005 in_ready  output  1  buffer can accept; high when occupancy < 2.
REQ-006 in_result  input  16  alu_result from the 16-bit ALU.
REQ-007 in_z, in_v, in_n  input  1 each  ALU zero, overflow and negative flags.
REQ-008 in_dest  input  3  destination register index.
REQ-009 in_wr_en  input  1  result is to be written to the register file.
REQ-010 in_flag_wr  input  1  instruction updates the architectural flags.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream (MEM/WB) accepts head.
REQ-013 out_result  output  16  head result; out_dest (3) and out_wr_en (1) are head fields.
REQ-014 flags  output  3  architectural {Z,V,N} register.
REQ-015 cond  input  3  branch condition code; br_taken  output  1  condition evaluated against flags.
REQ-016 flush  input  1  discard all buffered entries.
REQ-017 occupancy  output  2  entries held, 0..2.

Function
REQ-018 Storage SHALL be a 2-entry FIFO of {result[15:0], dest[2:0], wr_en}, with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-020 in_ready SHALL equal (count != 2) combinationally from registered count; there is no same-cycle pass-through of ready on pop when full.
REQ-021 Simultaneous push and pop with count == 1 SHALL leave count at 1, and the new entry SHALL become head on the next cycle.
REQ-022 Latency SHALL be 1 cycle: an entry pushed into an empty buffer appears on out_* with out_valid = 1 in the next cycle.
REQ-023 out_* SHALL be driven from the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-024 Pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow below 0.
REQ-025 Flags SHALL load {in_z, in_v, in_n} on any push with in_flag_wr = 1; flags SHALL otherwise hold.
REQ-026 br_taken SHALL be combinational from flags: 000 EQ = Z; 001 NE = !Z; 010 LT = N^V; 011 GE = !(N^V); 100 GT = !Z && !(N^V); 101 LE = Z || (N^V); 110 always = 1; 111 never = 0.
REQ-027 flush SHALL set count and both pointers to 0 on the next edge and SHALL take priority over push and pop in the same cycle.
REQ-028 A push attempted in a flush cycle SHALL be dropped, including its flag update; flags SHALL otherwise survive flush.
REQ-029 out_valid SHALL equal (count != 0).
REQ-030 Entry payload registers SHALL be non-reset datapath state.
REQ-031 When count == 0, out_result, out_dest and out_wr_en SHALL read 0.

Reset
REQ-032 On rst assertion, independent of clk, count SHALL be 0, both pointers SHALL be 0 and flags SHALL be 3'b000.
REQ-033 Consequently during and after rst: out_valid = 0, in_ready = 1, occupancy = 0, out_result = 0, and br_taken follows 3'b000 flags.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, with no partial pop visible.

Verification
REQ-035 Reset then push result 16'h1234 with dest 3, wr_en 1 and out_ready = 0 -> next cycle out_valid = 1, out_result = 16'h1234, occupancy = 1.
REQ-036 Push twice with out_ready = 0 -> occupancy = 2 and in_ready = 0; a third in_valid is ignored; raise out_ready -> entries emerge in order.
REQ-037 count = 1 with simultaneous push and pop -> occupancy stays 1 and the new head equals the pushed data.
REQ-038 Push with z = 0, v = 1, n = 0 and flag_wr = 1 -> flags = 3'b010, and cond 010 -> br_taken = 1; a following push with flag_wr = 0 -> flags unchanged.
REQ-039 count = 2 with flush, in_valid and flag_wr all high -> occupancy = 0 and flags unchanged next cycle.
REQ-040 Assert rst asynchronously between edges with count = 2 -> out_valid drops before the next edge and flags = 0.
